// File: rtl/key_input_conditioner.sv
// key_input_conditioner
//   Turns raw board buttons and switches into clean signals for the calculator core.
//   Every input passes through a two-flop synchroniser and a debouncer. Buttons also
//   go through a press-detect FSM that emits one-cycle key pulses.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   key_raw    raw buttons, active-low (bit0 -> pulse 2'b01, bit1 -> pulse 2'b10)
//   sw_raw     raw switches, polarity passed through
//   key_out    registered one-cycle press pulse, never 2'b11
//   key_level  debounced pressed level, active-high
//   sw_out     debounced switch level, same polarity as sw_raw
//   busy       any debounce counter nonzero, or a deferred key pulse pending
module key_input_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned CNT_W           = 16,
   parameter int unsigned N_SW            = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      key_raw,
   input  logic [N_SW-1:0] sw_raw,
   output logic [1:0]      key_out,
   output logic [1:0]      key_level,
   output logic [N_SW-1:0] sw_out,
   output logic            busy
);

   // Channels 0..1 are the buttons, 2..N_CH-1 the switches.
   localparam int unsigned     N_CH     = N_SW + 2;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {StIdle, StPressed} key_st_e;

   logic [N_CH-1:0]  raw;
   logic [N_CH-1:0]  sync1_q, sync2_q;
   logic [N_CH-1:0]  stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q [N_CH];
   logic [CNT_W-1:0] cnt_d [N_CH];
   logic [N_CH-1:0]  cnt_nz;
   key_st_e          key_st_q [2];
   key_st_e          key_st_d [2];
   logic [1:0]       press_ev;
   logic [1:0]       key_out_d;
   logic             pending_q, pending_d;

   assign raw = {sw_raw, key_raw};

   // Synchroniser, debounce state. Idle (released) level is 1 on every channel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q  <= '1;
         sync2_q  <= '1;
         stable_q <= '1;
         for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q  <= raw;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   // A level is accepted only after DEBOUNCE_CYCLES consecutive differing samples;
   // any agreeing sample in between restarts the count.
   always_comb begin
      stable_d = stable_q;
      cnt_nz   = '0;
      for (int i = 0; i < N_CH; i++) begin
         cnt_d[i]  = '0;
         cnt_nz[i] = |cnt_q[i];
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               stable_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Button FSMs: a press event fires only on the IDLE -> PRESSED transition.
   always_comb begin
      press_ev  = '0;
      key_level = '0;
      for (int i = 0; i < 2; i++) begin
         key_st_d[i] = key_st_q[i];
         unique case (key_st_q[i])
            StIdle: begin
               if (!stable_q[i]) begin
                  key_st_d[i] = StPressed;
                  press_ev[i] = 1'b1;
               end
            end
            StPressed: begin
               key_level[i] = 1'b1;
               if (stable_q[i]) key_st_d[i] = StIdle;
            end
            default: key_st_d[i] = StIdle;
         endcase
      end
   end

   // Key 0 wins a same-cycle collision; key 1 is deferred by one cycle. A key-1
   // event arriving while one is already deferred merges into it.
   always_comb begin
      key_out_d = 2'b00;
      pending_d = pending_q;
      if (press_ev[0]) begin
         key_out_d = 2'b01;
         pending_d = pending_q | press_ev[1];
      end else if (pending_q || press_ev[1]) begin
         key_out_d = 2'b10;
         pending_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_st_q[0] <= StIdle;
         key_st_q[1] <= StIdle;
         key_out     <= 2'b00;
         pending_q   <= 1'b0;
      end else begin
         key_st_q[0] <= key_st_d[0];
         key_st_q[1] <= key_st_d[1];
         key_out     <= key_out_d;
         pending_q   <= pending_d;
      end
   end

   assign sw_out = stable_q[N_CH-1:2];
   assign busy   = (|cnt_nz) | pending_q;

endmodule

// File: tb/tb_key_input_conditioner.sv
module tb_key_input_conditioner;

   localparam int D = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] key_raw = 2'b11;
   logic [3:0] sw_raw  = 4'b1111;
   logic [1:0] key_out;
   logic [1:0] key_level;
   logic [3:0] sw_out;
   logic       busy;

   key_input_conditioner #(
      .DEBOUNCE_CYCLES(D),
      .CNT_W          (4),
      .N_SW           (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .key_raw  (key_raw),
      .sw_raw   (sw_raw),
      .key_out  (key_out),
      .key_level(key_level),
      .sw_out   (sw_out),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   typedef struct {
      int         c;
      logic [1:0] v;
   } pulse_t;
   pulse_t plog[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic negs(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reference model: a level is accepted once the last D synchronised samples
   // (raw delayed by two edges) all disagree with the accepted level.
   logic [5:0] m_dly[$];
   logic [5:0] m_win[$];
   logic [5:0] m_stab;
   logic [1:0] m_lvl, m_out;
   logic       m_pend, m_busy;

   task automatic m_reset();
      m_dly.delete();
      m_dly.push_back(6'h3f);
      m_dly.push_back(6'h3f);
      m_win.delete();
      m_stab = 6'h3f;
      m_lvl  = 2'b00;
      m_out  = 2'b00;
      m_pend = 1'b0;
      m_busy = 1'b0;
   endtask

   task automatic m_step();
      logic [5:0] s;
      logic [1:0] ev;
      bit         all_diff;
      s = m_dly.pop_front();
      m_dly.push_back({sw_raw, key_raw});
      // Press = accepted level is low but the pressed indication has not caught up.
      ev = ~m_stab[1:0] & ~m_lvl;
      if (ev[0]) begin
         m_out  = 2'b01;
         m_pend = m_pend | ev[1];
      end else if (m_pend) begin
         m_out  = 2'b10;
         m_pend = 1'b0;
      end else if (ev[1]) begin
         m_out = 2'b10;
      end else begin
         m_out = 2'b00;
      end
      m_lvl = ~m_stab[1:0];
      m_win.push_back(s);
      if (m_win.size() > D) void'(m_win.pop_front());
      if (m_win.size() == D) begin
         for (int ch = 0; ch < 6; ch++) begin
            all_diff = 1'b1;
            foreach (m_win[k]) if (m_win[k][ch] == m_stab[ch]) all_diff = 1'b0;
            if (all_diff) m_stab[ch] = ~m_stab[ch];
         end
      end
      m_busy = m_pend;
      for (int ch = 0; ch < 6; ch++)
         if (m_win[m_win.size()-1][ch] != m_stab[ch]) m_busy = 1'b1;
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) m_reset();
         else m_step();
      end
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Every-cycle comparison against the model, plus the pulse log.
   initial forever begin
      @(negedge clk);
      chk("key_out", key_out, m_out);
      chk("key_level", key_level, m_lvl);
      chk("sw_out", sw_out, m_stab[5:2]);
      chk("busy", busy, m_busy);
      chk("key_out_not_11", key_out == 2'b11, 1'b0);
      if (key_out != 2'b00) plog.push_back('{cyc, key_out});
   end

   initial begin
      int e0;
      negs(3);
      rst = 1'b0;

      // Reset asserted mid-run takes effect immediately.
      sw_raw = 4'b0000;
      negs(15);
      #2 rst = 1'b1;
      #1;
      chk("rst_key_out", key_out, 2'b00);
      chk("rst_key_level", key_level, 2'b00);
      chk("rst_sw_out", sw_out, 4'b1111);
      chk("rst_busy", busy, 1'b0);
      negs(2);
      sw_raw = 4'b1111;
      rst    = 1'b0;
      negs(15);

      // Clean press and release.
      plog.delete();
      key_raw = 2'b10;
      e0 = cyc;
      negs(20);
      chk("press_level", key_level, 2'b01);
      chk("press_count", plog.size(), 1);
      if (plog.size() >= 1) begin
         chk("press_time", plog[0].c, e0 + 11);
         chk("press_val", plog[0].v, 2'b01);
      end
      plog.delete();
      key_raw = 2'b11;
      negs(20);
      chk("release_count", plog.size(), 0);
      chk("release_level", key_level, 2'b00);

      // Bounce on key 1, then held low.
      plog.delete();
      for (int i = 0; i <= 10; i++) begin
         key_raw[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
         e0 = cyc;
         if (i < 10) negs(3);
      end
      negs(20);
      chk("bounce_count", plog.size(), 1);
      if (plog.size() >= 1) begin
         chk("bounce_time", plog[0].c, e0 + 11);
         chk("bounce_val", plog[0].v, 2'b10);
      end
      key_raw = 2'b11;
      negs(20);

      // Simultaneous press.
      plog.delete();
      key_raw = 2'b00;
      e0 = cyc;
      negs(20);
      chk("simul_count", plog.size(), 2);
      if (plog.size() >= 2) begin
         chk("simul_t0", plog[0].c, e0 + 11);
         chk("simul_v0", plog[0].v, 2'b01);
         chk("simul_t1", plog[1].c, e0 + 12);
         chk("simul_v1", plog[1].v, 2'b10);
      end
      chk("simul_level", key_level, 2'b11);
      key_raw = 2'b11;
      negs(20);

      // Switch glitch.
      sw_raw = 4'b1010;
      negs(4);
      sw_raw = 4'b1111;
      negs(5);
      sw_raw = 4'b1010;
      e0 = cyc;
      negs(9);
      chk("glitch_hold", sw_out, 4'b1111);
      negs(1);
      chk("glitch_done", sw_out, 4'b1010);
      sw_raw = 4'b1111;
      negs(20);

      // Reset in the middle of qualifying a press.
      plog.delete();
      key_raw = 2'b10;
      negs(5);
      #2 rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      e0 = cyc;
      negs(20);
      chk("rstq_count", plog.size(), 1);
      if (plog.size() >= 1) begin
         chk("rstq_time", plog[0].c, e0 + 11);
         chk("rstq_val", plog[0].v, 2'b01);
      end
      key_raw = 2'b11;
      negs(20);

      // Random activity, checked every cycle against the model.
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         rst = 1'b0;
         for (int b = 0; b < 2; b++) if ($urandom_range(11) == 0) key_raw[b] = ~key_raw[b];
         for (int b = 0; b < 4; b++) if ($urandom_range(11) == 0) sw_raw[b] = ~sw_raw[b];
         if ($urandom_range(499) == 0) rst = 1'b1;
      end
      @(negedge clk);
      rst = 1'b0;
      negs(30);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/key_input_conditioner.md
Name: key_input_conditioner

Overview:
- Input-side counterpart to the calculator's display path. Conditions the raw board buttons and switches into the clean signals the calculator core consumes.
- Synchronises, debounces and edge-detects two active-low push buttons. Emits single-cycle key pulses in the calculator's 2-bit key encoding (2'b01 = store operand 2, 2'b10 = store operand 1).
- Delivers debounced switch levels with the raw polarity preserved, so the downstream inversion is unchanged.

Parameters:
- DEBOUNCE_CYCLES, 50000, number of consecutive stable synchronised samples required to accept a level change (1 ms at 50 MHz); minimum 2.
- CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- N_SW, 4, number of switch inputs.

Ports:
- clk  input  1  system clock; all flops on rising edge.
- rst  input  1  asynchronous active-high reset.
- key_raw  input  2  raw buttons, active-low; bit0 maps to pulse 2'b01, bit1 maps to pulse 2'b10.
- sw_raw  input  N_SW  raw switches, polarity passed through.
- key_out  output  2  one-cycle press pulse, registered; never 2'b11.
- key_level  output  2  debounced pressed level, active-high.
- sw_out  output  N_SW  debounced switch level, same polarity as sw_raw.
- busy  output  1  high while any debounce counter is nonzero or a deferred pulse is pending.

Behaviour:
- Reset (async, any time): sync flops = 1 (released/idle); stable regs = 1; counters = 0; key_out = 2'b00; key_level = 2'b00; sw_out = {N_SW{1'b1}}; busy = 0; pending = 0.
- Releasing rst mid-bounce restarts qualification from zero.
- Synchroniser: two-flop chain per input, so the synchronised value lags raw by 2 edges.
- Debounce, per input (6 identical channels):
  - Counter increments each cycle that sync != stable.
  - Counter clears to 0 on any cycle that sync == stable (glitch restarts the count).
  - On the edge where the counter would reach DEBOUNCE_CYCLES: stable <= sync, counter <= 0.
  - Net latency: sw_out changes DEBOUNCE_CYCLES+2 edges after the first edge sampling the new raw value, if raw holds steady.
- Button FSM, per key: IDLE (released) -> PRESSED when stable falls to 0; PRESSED -> IDLE when stable rises to 1.
  - key_level[i] = 1 in PRESSED.
  - Press event on IDLE->PRESSED only; no event on release; no auto-repeat while held.
- Pulse output (registered):
  - key_out asserts one cycle after the press event, for exactly one cycle.
  - Total press latency: DEBOUNCE_CYCLES+3 edges.
- Simultaneous press events in the same cycle: key_out = 2'b01 first; the key1 event is latched in pending and emitted as 2'b10 in the next cycle. key_out is never 2'b11.
- A press event for a key arriving while its own pending is set is merged (at most one deferred pulse).
- Switches have no FSM; sw_out = stable register directly.
- busy = OR of all counters nonzero, OR pending.

Test Plan (bench uses DEBOUNCE_CYCLES=8):
- Reset: assert rst mid-run with key_raw=2'b11, sw_raw=4'b0000 -> outputs immediately key_out=0, key_level=0, sw_out=4'b1111, busy=0.
- Clean press: key_raw[0] 1->0 and held -> key_out=2'b01 for exactly one cycle, 11 edges after the change; key_level=2'b01 while held; no further pulses; release gives no pulse and key_level returns to 0.
- Bounce: key_raw[1] toggles every 3 cycles for 30 cycles, then held low -> no pulse during bounce; a single key_out=2'b10 pulse 11 edges after the final transition.
- Simultaneous: both buttons fall on the same edge -> key_out=2'b01 at edge+11, 2'b10 at edge+12; 2'b11 never seen.
- Switch glitch: sw_raw 4'b1111 -> 4'b1010 with a 5-cycle glitch back to 1111 after 4 cycles -> sw_out stays 1111 through the glitch, becomes 1010 exactly 10 edges after the final stable change.
- Reset mid-qualification: rst pulse at 5 cycles into a press -> no pulse; the press re-qualifies fully (11 edges) after rst deasserts.
